// File: rtl/eu_operand_collector_pkg.sv
// Shared types for the execution-unit operand collector: FSM state encoding,
// the slot record layout and the post-acceptance state decision.
package eu_operand_collector_pkg;

  localparam int OC_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } type_collector_state;

  typedef struct packed {
    logic                 valid;
    logic                 isforeign;
    logic [OC_DATA_W-1:0] data;
  } type_operand_slot;

  // An instruction whose operands are all immediates needs no collection.
  function automatic type_collector_state state_after_accept(input logic all_imm);
    return all_imm ? ISSUE : COLLECT;
  endfunction

endpackage

// File: rtl/eu_operand_collector_if.sv
// Queue-side, source-side and ALU-side signals of one operand collector.
// The master modport drives instructions and sources; the slave modport is the collector.
interface eu_operand_collector_if #(
  parameter int NUM_OPS = 2,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 4
);
  logic                      instr_valid_i;
  logic                      instr_ready_o;
  logic [TAG_W-1:0]          instr_tag_i;
  logic [NUM_OPS-1:0]        op_isreg_i;
  logic [NUM_OPS-1:0]        op_isforeign_i;
  logic [NUM_OPS*DATA_W-1:0] op_imm_i;
  logic [NUM_OPS*DATA_W-1:0] loc_data_i;
  logic [NUM_OPS-1:0]        loc_success_i;
  logic [NUM_OPS*DATA_W-1:0] for_data_i;
  logic [NUM_OPS-1:0]        for_success_i;
  logic                      flush_i;
  logic                      alu_valid_o;
  logic                      alu_ready_i;
  logic [TAG_W-1:0]          alu_tag_o;
  logic [NUM_OPS*DATA_W-1:0] alu_ops_o;
  logic [CNT_W-1:0]          wait_cycles_o;
  logic                      busy_o;

  modport master (
    output instr_valid_i, instr_tag_i, op_isreg_i, op_isforeign_i, op_imm_i,
           loc_data_i, loc_success_i, for_data_i, for_success_i, flush_i, alu_ready_i,
    input  instr_ready_o, alu_valid_o, alu_tag_o, alu_ops_o, wait_cycles_o, busy_o
  );

  modport slave (
    input  instr_valid_i, instr_tag_i, op_isreg_i, op_isforeign_i, op_imm_i,
           loc_data_i, loc_success_i, for_data_i, for_success_i, flush_i, alu_ready_i,
    output instr_ready_o, alu_valid_o, alu_tag_o, alu_ops_o, wait_cycles_o, busy_o
  );
endinterface

// File: rtl/eu_operand_collector_slot.sv
// One operand slot: loads an immediate or arms for a register read, then
// holds the first hit from whichever source bus the operand was routed to.
module eu_operand_slot #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              isreg_i,
  input  logic              isforeign_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              collect_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] loc_data_i,
  input  logic              loc_hit_i,
  input  logic [DATA_W-1:0] for_data_i,
  input  logic              for_hit_i,
  output logic              valid_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic              isforeign_q, isforeign_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] cap_data;

  // Gating on ~valid_q keeps the first hit; the unselected bus never matters.
  assign hit_o    = collect_i & ~valid_q & (isforeign_q ? for_hit_i : loc_hit_i);
  assign cap_data = isforeign_q ? for_data_i : loc_data_i;

  always_comb begin
    valid_d     = valid_q;
    isforeign_d = isforeign_q;
    data_d      = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d     = ~isreg_i;
      isforeign_d = isforeign_i;
      data_d      = isreg_i ? '0 : imm_i;
    end else if (hit_o) begin
      valid_d = 1'b1;
      data_d  = cap_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      isforeign_q <= 1'b0;
      data_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      isforeign_q <= isforeign_d;
      data_q      <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/eu_operand_collector.sv
// Operand collector between the instruction queue head and the ALU: FSM,
// tag and wait counter here, per-operand capture in eu_operand_slot.
module eu_operand_collector
  import eu_operand_collector_pkg::*;
#(
  parameter int NUM_OPS = 2,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  eu_operand_collector_if.slave  oc
);

  type_collector_state state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [CNT_W-1:0]    wait_q, wait_d;

  logic [NUM_OPS-1:0][DATA_W-1:0] imm_a, loc_a, for_a, slot_data;
  logic [NUM_OPS-1:0]             slot_vld, slot_hit;
  logic accept, handshake, collect, all_imm, all_ready, slot_clear;

  assign imm_a = oc.op_imm_i;
  assign loc_a = oc.loc_data_i;
  assign for_a = oc.for_data_i;

  assign oc.instr_ready_o = ~oc.flush_i & ((state_q == IDLE) |
                                           ((state_q == ISSUE) & oc.alu_ready_i));
  assign accept     = oc.instr_valid_i & oc.instr_ready_o;
  assign oc.alu_valid_o = (state_q == ISSUE) & ~oc.flush_i;
  assign handshake  = oc.alu_valid_o & oc.alu_ready_i;
  assign collect    = (state_q == COLLECT) & ~oc.flush_i;
  assign all_imm    = ~|oc.op_isreg_i;
  // Slots captured this cycle count toward completion.
  assign all_ready  = &(slot_vld | slot_hit);
  assign slot_clear = oc.flush_i | (handshake & ~accept);

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_slot
    eu_operand_slot #(.DATA_W(DATA_W)) u_slot (
      .clk         (clk),
      .rst_n       (reset_n),
      .load_i      (accept),
      .isreg_i     (oc.op_isreg_i[g]),
      .isforeign_i (oc.op_isforeign_i[g]),
      .imm_i       (imm_a[g]),
      .collect_i   (collect),
      .clear_i     (slot_clear),
      .loc_data_i  (loc_a[g]),
      .loc_hit_i   (oc.loc_success_i[g]),
      .for_data_i  (for_a[g]),
      .for_hit_i   (oc.for_success_i[g]),
      .valid_o     (slot_vld[g]),
      .hit_o       (slot_hit[g]),
      .data_o      (slot_data[g])
    );
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    wait_d  = wait_q;
    if (oc.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: ;
        COLLECT: begin
          if (wait_q != {CNT_W{1'b1}}) wait_d = wait_q + CNT_W'(1);
          if (all_ready) state_d = ISSUE;
        end
        ISSUE: if (handshake) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (accept) begin
        state_d = state_after_accept(all_imm);
        tag_d   = oc.instr_tag_i;
        wait_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      wait_q  <= wait_d;
    end
  end

  assign oc.alu_tag_o     = tag_q;
  assign oc.alu_ops_o     = slot_data;
  assign oc.wait_cycles_o = wait_q;
  assign oc.busy_o        = (state_q != IDLE);

endmodule
